// File: rtl/rx_bit_timer_ctrl.sv
// Purpose : bit-period sequencer for a serial receiver (start, DATA_BITS data, one stop bit).
// Latency : k-th shift_strobe k*CLKS_PER_BIT+SAMPLE_AT cycles after start is sampled; packet_done one cycle after the stop strobe.
// Backpres: none; start_detected is only honoured in IDLE, and abort returns to IDLE on the next edge.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start_detected  start-edge indication from the detector (level or pulse)
//   abort           drops the frame in progress
//   busy            frame being timed (RUN or DONE)
//   shift_strobe    one-cycle mid-bit sample/shift pulse for data and stop bits
//   packet_done     one-cycle end-of-frame pulse following the stop-bit strobe
//   bit_index       current bit period: 0 start, 1..DATA_BITS data, DATA_BITS+1 stop

module rx_bit_timer_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_AT    = 5,
  parameter int DATA_BITS    = 8,
  localparam int BIT_W       = $clog2(DATA_BITS + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_detected,
  input  logic             abort,
  output logic             busy,
  output logic             shift_strobe,
  output logic             packet_done,
  output logic [BIT_W-1:0] bit_index
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] CPB_C    = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(SAMPLE_AT);
  localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;

  logic             sample_pt;
  logic             stop_sample;

  // Mid-bit sample point of the current period; shared by the strobe
  // decode and the RUN->DONE decision so both line up on the same cycle.
  assign sample_pt   = (state == RUN) && (clk_cnt == SAMPLE_C);
  assign stop_sample = sample_pt && (bit_cnt == STOP_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        // abort takes priority over a coincident start
        if (start_detected && !abort) begin
          state_nxt   = RUN;
          clk_cnt_nxt = CNT_W'(1);
        end
      end

      RUN: begin
        if (abort || stop_sample) begin
          // The stop bit is not waited out: leave at its sample point.
          // Counters clear here so bit_cnt never steps past the stop index.
          state_nxt   = abort ? IDLE : DONE;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end else if (clk_cnt == CPB_C) begin
          clk_cnt_nxt = CNT_W'(1);
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
      end

      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // All outputs are pure decodes of registered state, so they cannot glitch
  // on input changes. The start period (bit_cnt==0) never strobes.
  assign busy         = (state == RUN) || (state == DONE);
  assign packet_done  = (state == DONE);
  assign shift_strobe = sample_pt && (bit_cnt != '0);
  assign bit_index    = (state == RUN) ? bit_cnt : '0;

endmodule

// File: tb/tb_rx_bit_timer_ctrl.sv
// Purpose : directed bench for rx_bit_timer_ctrl, default and minimum-size configurations side by side.
// Latency : n/a (bench).
// Backpres: n/a (bench).

module tb_rx_bit_timer_ctrl;

  localparam int C0_CPB = 10;
  localparam int C0_SA  = 5;
  localparam int C0_DB  = 8;
  localparam int C1_CPB = 2;
  localparam int C1_SA  = 2;
  localparam int C1_DB  = 1;

  logic       tb_clk = 1'b0;
  logic       rst;
  logic       start0, abort0, start1, abort1;
  logic       busy0, shift_strobe0, packet_done0;
  logic       busy1, shift_strobe1, packet_done1;
  logic [3:0] idx0;
  logic [1:0] idx1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // reference model state: frame in progress and the cycle its start was sampled
  bit m_act [2];
  int m_t0  [2];

  // pulse logs, stored relative to the base cycle of the current test
  int base0 = 0;
  int base1 = 0;
  int sq0[$], dq0[$], sq1[$], dq1[$];

  always #5 tb_clk = ~tb_clk;

  rx_bit_timer_ctrl #(.CLKS_PER_BIT(C0_CPB), .SAMPLE_AT(C0_SA), .DATA_BITS(C0_DB)) dut0 (
    .clk(tb_clk), .rst(rst), .start_detected(start0), .abort(abort0),
    .busy(busy0), .shift_strobe(shift_strobe0), .packet_done(packet_done0), .bit_index(idx0)
  );

  rx_bit_timer_ctrl #(.CLKS_PER_BIT(C1_CPB), .SAMPLE_AT(C1_SA), .DATA_BITS(C1_DB)) dut1 (
    .clk(tb_clk), .rst(rst), .start_detected(start1), .abort(abort1),
    .busy(busy1), .shift_strobe(shift_strobe1), .packet_done(packet_done1), .bit_index(idx1)
  );

  function automatic int p_cpb(int c); return (c == 0) ? C0_CPB : C1_CPB; endfunction
  function automatic int p_sa(int c);  return (c == 0) ? C0_SA  : C1_SA;  endfunction
  function automatic int p_db(int c);  return (c == 0) ? C0_DB  : C1_DB;  endfunction

  // frame offset of the packet_done cycle
  function automatic int t_done(int c);
    return (p_db(c) + 1) * p_cpb(c) + p_sa(c) + 1;
  endfunction

  function automatic bit in_start(int c); return (c == 0) ? start0 : start1; endfunction
  function automatic bit in_abort(int c); return (c == 0) ? abort0 : abort1; endfunction

  // Expected output for the current cycle from frame offset d.
  // sig: 0 busy, 1 strobe, 2 done, 3 bit_index (-1 = not checked).
  function automatic int exp_val(int c, int sig);
    int d;
    if (!m_act[c]) return 0;
    d = cyc - m_t0[c];
    case (sig)
      0:       return 1;
      1:       return (d < t_done(c) && d >= p_cpb(c) + p_sa(c) && (d - p_sa(c)) % p_cpb(c) == 0) ? 1 : 0;
      2:       return (d == t_done(c)) ? 1 : 0;
      default: return (d == t_done(c)) ? -1 : (d - 1) / p_cpb(c);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int q[$], input int exp[$]);
    chk({name, "_count"}, q.size(), exp.size());
    for (int i = 0; i < q.size() && i < exp.size(); i++)
      chk({name, "_at"}, q[i], exp[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  // model update: inputs of the cycle now ending decide the next cycle
  always @(posedge tb_clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_act[c] <= 1'b0;
      end else if (m_act[c]) begin
        if (in_abort(c) || (cyc - m_t0[c]) == t_done(c)) m_act[c] <= 1'b0;
      end else if (in_start(c) && !in_abort(c)) begin
        m_act[c] <= 1'b1;
        m_t0[c]  <= cyc;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge tb_clk) begin : cmp
    int e;
    if (chk_en) begin
      chk("busy0",   busy0,         exp_val(0, 0));
      chk("strobe0", shift_strobe0, exp_val(0, 1));
      chk("done0",   packet_done0,  exp_val(0, 2));
      e = exp_val(0, 3);
      if (e >= 0) chk("idx0", idx0, e);
      chk("busy1",   busy1,         exp_val(1, 0));
      chk("strobe1", shift_strobe1, exp_val(1, 1));
      chk("done1",   packet_done1,  exp_val(1, 2));
      e = exp_val(1, 3);
      if (e >= 0) chk("idx1", idx1, e);
    end
  end

  always @(negedge tb_clk) begin
    if (shift_strobe0 === 1'b1) sq0.push_back(cyc - base0);
    if (packet_done0  === 1'b1) dq0.push_back(cyc - base0);
    if (shift_strobe1 === 1'b1) sq1.push_back(cyc - base1);
    if (packet_done1  === 1'b1) dq1.push_back(cyc - base1);
  end

  initial begin
    int es[$];
    int ed[$];

    rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    tick(2);
    chk_en = 1'b1;
    chk("rst_busy0", busy0, 0);
    chk("rst_strobe0", shift_strobe0, 0);
    chk("rst_done0", packet_done0, 0);
    chk("rst_idx0", idx0, 0);
    rst = 1'b0;
    tick(2);

    // reset in the middle of a frame
    start0 = 1'b1; tick(1); start0 = 1'b0; tick(29);
    chk("t1_busy_run", busy0, 1);
    chk("t1_idx_run", idx0, 2);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t1_busy", busy0, 0);
    chk("t1_strobe", shift_strobe0, 0);
    chk("t1_done", packet_done0, 0);
    chk("t1_idx", idx0, 0);
    tick(3);

    // full frame
    sq0.delete(); dq0.delete(); base0 = cyc;
    start0 = 1'b1; tick(1); start0 = 1'b0; tick(94);
    chk("t2_strobe95", shift_strobe0, 1);
    chk("t2_idx95", idx0, 9);
    tick(1);
    chk("t2_done96", packet_done0, 1);
    chk("t2_busy96", busy0, 1);
    tick(1);
    chk("t2_busy97", busy0, 0);
    chk("t2_done97", packet_done0, 0);
    tick(5);
    es.delete(); ed.delete();
    for (int k = 0; k < 9; k++) es.push_back(15 + 10 * k);
    ed.push_back(96);
    chk_q("t2_strobes", sq0, es);
    chk_q("t2_dones", dq0, ed);

    // abort mid-frame, then restart
    sq0.delete(); dq0.delete(); base0 = cyc;
    start0 = 1'b1; tick(1); start0 = 1'b0; tick(39);
    chk("t3_busy40", busy0, 1);
    abort0 = 1'b1; tick(1); abort0 = 1'b0;
    chk("t3_busy41", busy0, 0);
    tick(4);
    start0 = 1'b1; tick(1); start0 = 1'b0; tick(14);
    chk("t3_strobe60", shift_strobe0, 1);
    tick(90);
    es.delete(); ed.delete();
    es.push_back(15); es.push_back(25); es.push_back(35);
    for (int k = 0; k < 9; k++) es.push_back(60 + 10 * k);
    ed.push_back(141);
    chk_q("t3_strobes", sq0, es);
    chk_q("t3_dones", dq0, ed);

    // start held high through a whole frame
    sq0.delete(); dq0.delete(); base0 = cyc;
    start0 = 1'b1; tick(97);
    chk("t4_busy97", busy0, 0);
    tick(1);
    chk("t4_busy98", busy0, 1);
    start0 = 1'b0; tick(100);
    es.delete(); ed.delete();
    for (int k = 0; k < 9; k++) es.push_back(15 + 10 * k);
    for (int k = 0; k < 9; k++) es.push_back(112 + 10 * k);
    ed.push_back(96); ed.push_back(193);
    chk_q("t4_strobes", sq0, es);
    chk_q("t4_dones", dq0, ed);

    // minimum configuration: full frame
    sq1.delete(); dq1.delete(); base1 = cyc;
    start1 = 1'b1; tick(1); start1 = 1'b0; tick(3);
    chk("t5_strobe4", shift_strobe1, 1);
    chk("t5_idx4", idx1, 1);
    tick(2);
    chk("t5_strobe6", shift_strobe1, 1);
    chk("t5_idx6", idx1, 2);
    tick(1);
    chk("t5_done7", packet_done1, 1);
    tick(1);
    chk("t5_busy8", busy1, 0);
    tick(2);
    es.delete(); ed.delete();
    es.push_back(4); es.push_back(6); ed.push_back(7);
    chk_q("t5_strobes", sq1, es);
    chk_q("t5_dones", dq1, ed);

    // simultaneous start and abort in IDLE
    sq1.delete(); dq1.delete(); base1 = cyc;
    start1 = 1'b1; abort1 = 1'b1; tick(1); start1 = 1'b0; abort1 = 1'b0;
    chk("t5_sim_busy", busy1, 0);
    tick(10);
    es.delete(); ed.delete();
    chk_q("t5_sim_strobes", sq1, es);
    chk_q("t5_sim_dones", dq1, ed);

    // abort on a strobe cycle: strobe still emitted, no packet_done
    sq1.delete(); dq1.delete(); base1 = cyc;
    start1 = 1'b1; tick(1); start1 = 1'b0; tick(3);
    abort1 = 1'b1;
    chk("t5_ab_strobe4", shift_strobe1, 1);
    tick(1); abort1 = 1'b0;
    chk("t5_ab_busy5", busy1, 0);
    tick(10);
    es.delete(); ed.delete();
    es.push_back(4);
    chk_q("t5_ab_strobes", sq1, es);
    chk_q("t5_ab_dones", dq1, ed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
